shift_reg_seq: RTL
==================

Name: shift_reg_seq

Overview:
- Parametrised successor to the team's single-bit synchronous-reset D register: a WIDTH-bit universal shift register.
- Supports hold, shift, rotate, parallel load and clear, selected by a mode input.
- A built-in serializer sequencer loads a parallel word and shifts it out MSB-first with busy/done handshake.
- Sits between parallel datapath logic and serial links/LED or UART-style outputs.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH), width of internal shift counter (derived, not overridden).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- en  in  1  clock enable; 0 freezes register, FSM and counter
- mode  in  3  operation select (manual mode, ignored while busy)
- sin  in  1  serial input bit
- pin  in  WIDTH  parallel load data
- start  in  1  serializer start request, sampled only in IDLE
- pout  out  WIDTH  register contents (registered)
- sout_msb  out  1  pout[WIDTH-1], combinational from register
- sout_lsb  out  1  pout[0], combinational from register
- busy  out  1  serializer active (registered)
- done  out  1  one-cycle pulse at serializer completion (registered)

Behaviour:
- Reset: rst=0 at a rising edge -> pout=0, busy=0, done=0, counter=0, state IDLE. Reset overrides en, start and mode. Reset mid-serialization aborts it; no done pulse.
- en=0: all registers hold, including done. A pending done pulse stays asserted until the next en=1 edge.
- Manual modes apply in IDLE with start=0 and en=1:
  - 000 hold
  - 001 shift left: q <= {q[WIDTH-2:0], sin}
  - 010 shift right: q <= {sin, q[WIDTH-1:1]}
  - 011 rotate left
  - 100 rotate right
  - 101 load: q <= pin
  - 110 clear: q <= 0
  - 111 reserved, behaves as hold
- FSM states: IDLE, SHIFT.
- IDLE & start & en:
  - q <= pin, counter <= 0, busy <= 1, state -> SHIFT.
  - start takes priority over mode in the same cycle.
- SHIFT & en: each edge q <= {q[WIDTH-2:0], sin}, counter++.
- Last bit: when counter == WIDTH-1 at an enabled edge -> state IDLE, busy <= 0, done <= 1, counter <= 0.
- done deasserts at the next enabled edge.
- Serializer timing:
  - busy is high for exactly WIDTH enabled cycles.
  - sout_msb presents pin[WIDTH-1] down to pin[0], one bit per enabled cycle, starting the cycle after start is sampled.
  - done rises on the cycle after the last bit is presented.
- start while busy: ignored, no queuing. mode while busy: ignored.
- start and done in the same cycle (back-to-back):
  - Legal: start in the cycle done=1 with state IDLE begins a new word.
  - done clears and busy re-asserts at that edge. No idle gap required.
- After completion pout holds the WIDTH sin bits shifted in; there is no auto-clear.

Decomposition:
- Shared package shift_reg_pkg:
  - mode encodings as localparams: MODE_HOLD, MODE_SHL, MODE_SHR, MODE_ROTL, MODE_ROTR, MODE_LOAD, MODE_CLR.
  - FSM state encoding: ST_IDLE, ST_SHIFT.
- One sub-module: shift_reg_core, the WIDTH-bit register plus next-value mux driven by an internal op select.
- The top owns the FSM, counter, busy/done and the mode/start arbitration.

Test Plan:
- Reset: WIDTH=8, drive pin=0xFF, mode=101, rst=0 for 2 cycles -> pout=0x00, busy=0, done=0 throughout; first enabled edge after rst=1 -> pout=0xFF.
- Manual modes: load 0x81, then rotl -> 0x03; rotr twice -> 0xC0; shl with sin=1 -> 0x81; shr with sin=0 -> 0x40; clear -> 0x00; 111 -> unchanged.
- Serializer: pin=0xA5, start pulse, sin=0 -> sout_msb = 1,0,1,0,0,1,0,1 over 8 cycles.
  - busy high exactly those 8 cycles.
  - done=1 for one cycle after, then pout=0x00.
- Stall/ignore: during serialization of 0x3C hold en=0 for 3 cycles mid-word and pulse start plus mode=110.
  - Bit sequence 0,0,1,1,1,1,0,0 is intact, only stretched.
  - busy spans 8 enabled cycles; no restart, no clear.
- Back-to-back and abort:
  - Start 0xF0, assert start again in the done cycle with pin=0x0F -> second word follows immediately with no gap.
  - Separately, assert rst=0 at bit 4 -> pout=0, busy=0, done never pulses.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// Shared definitions for the shift_reg_seq universal shift register and serializer.
package shift_reg_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'd0;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'd1;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'd2;
  localparam logic [MODE_W-1:0] MODE_ROTL = 3'd3;
  localparam logic [MODE_W-1:0] MODE_ROTR = 3'd4;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'd5;
  localparam logic [MODE_W-1:0] MODE_CLR  = 3'd6;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/shift_reg_core.sv
// WIDTH-bit register with a next-value mux; any op outside the known set holds.
module shift_reg_core
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [MODE_W-1:0] op,
  input  logic              sin,
  input  logic [WIDTH-1:0]  pin,
  output logic [WIDTH-1:0]  q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    case (op)
      MODE_SHL:  q_d = {q_q[WIDTH-2:0], sin};
      MODE_SHR:  q_d = {sin, q_q[WIDTH-1:1]};
      MODE_ROTL: q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
      MODE_ROTR: q_d = {q_q[0], q_q[WIDTH-1:1]};
      MODE_LOAD: q_d = pin;
      MODE_CLR:  q_d = '0;
      default:   q_d = q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/shift_reg_seq.sv
// Universal shift register with an MSB-first serializer; the FSM arbitrates
// between start and the manual mode and steers the core's op select.
module shift_reg_seq
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic              sin,
  input  logic [WIDTH-1:0]  pin,
  input  logic              start,
  output logic [WIDTH-1:0]  pout,
  output logic              sout_msb,
  output logic              sout_lsb,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [MODE_W-1:0] op;

  // With en low the op stays HOLD so the core freezes along with the FSM.
  always_comb begin
    op      = MODE_HOLD;
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    if (en) begin
      done_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op      = MODE_LOAD;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = ST_SHIFT;
          end else begin
            op = mode;
          end
        end
        ST_SHIFT: begin
          op = MODE_SHL;
          if (cnt_q == CNT_LAST) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  shift_reg_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk(clk),
    .rst(rst),
    .op (op),
    .sin(sin),
    .pin(pin),
    .q  (pout)
  );

  assign sout_msb = pout[WIDTH-1];
  assign sout_lsb = pout[0];
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
